// File: rtl/irq_controller.sv
// Vectored priority-nesting interrupt controller: sync, level/edge latch, mask, nest, request/ack to CPU.
// Latency: irq_in change to irq_out is SYNC_STAGES+1 cycles; read_data is combinational from address.
// Backpressure: a request is held (irq_id may be upgraded) until irq_ack or until no line is eligible.
module irq_controller #(
    parameter int NUM_LINES   = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LINES-1:0] irq_in,
    input  logic [1:0]           address,
    input  logic                 write_enable,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    output logic                 irq_out,
    output logic [2:0]           irq_id,
    input  logic                 irq_ack
);

    typedef enum logic {IDLE, REQ} state_t;

    logic [SYNC_STAGES-1:0][NUM_LINES-1:0] sync_ff;
    logic [NUM_LINES-1:0] sync_w, prev_q, mask_q, edge_q, edge_lat_q, in_service_q;
    logic [NUM_LINES-1:0] wr_bits, rise, pending, above, eligible, is_top;
    logic [NUM_LINES-1:0] ack_set, lat_clr, edge_chg;
    logic [2:0]           hi_elig, irq_id_d, irq_id_q;
    state_t               state_q, state_d;
    logic                 wr_mask, wr_edge, wr_pend, wr_eoi;
    logic                 unused_wdata;

    assign unused_wdata = ^write_data[31:NUM_LINES];
    assign wr_bits      = write_data[NUM_LINES-1:0];
    assign wr_mask      = write_enable && (address == 2'd0);
    assign wr_edge      = write_enable && (address == 2'd1);
    assign wr_pend      = write_enable && (address == 2'd2);
    assign wr_eoi       = write_enable && (address == 2'd3);

    assign sync_w = sync_ff[SYNC_STAGES-1];
    // The live rising edge feeds pending directly so edge lines match level-line latency.
    assign rise    = sync_w & ~prev_q & edge_q;
    assign pending = (edge_q & (edge_lat_q | rise)) | (~edge_q & sync_w);

    always_comb begin
        above   = '0;
        is_top  = '0;
        hi_elig = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            above[i] = ~|(in_service_q >> i);
            if (in_service_q[i]) begin
                is_top    = '0;
                is_top[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_LINES; i++) begin
            if (eligible[i]) hi_elig = 3'(i);
        end
    end

    assign eligible = pending & mask_q & ~in_service_q & above;

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        ack_set  = '0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d  = REQ;
                    irq_id_d = hi_elig;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d           = IDLE;
                    ack_set[irq_id_q] = 1'b1;
                end else if (|eligible) begin
                    irq_id_d = hi_elig;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign lat_clr  = (wr_pend ? wr_bits : '0) | ack_set;
    assign edge_chg = wr_edge ? (edge_q ^ wr_bits) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff      <= '0;
            prev_q       <= '0;
            mask_q       <= '0;
            edge_q       <= '0;
            edge_lat_q   <= '0;
            in_service_q <= '0;
            state_q      <= IDLE;
            irq_id_q     <= '0;
        end else begin
            sync_ff  <= {sync_ff[SYNC_STAGES-2:0], irq_in};
            prev_q   <= sync_w;
            state_q  <= state_d;
            irq_id_q <= irq_id_d;
            if (wr_mask) mask_q <= wr_bits;
            if (wr_edge) edge_q <= wr_bits;
            // A new edge beats W1C/ack clears; a mode change always empties the latch.
            edge_lat_q   <= ((edge_lat_q & ~lat_clr) | rise) & ~edge_chg;
            in_service_q <= (in_service_q & ~(wr_eoi ? is_top : '0)) | ack_set;
        end
    end

    assign irq_out = (state_q == REQ);
    assign irq_id  = irq_id_q;

    always_comb begin
        read_data = '0;
        case (address)
            2'd0:    read_data[NUM_LINES-1:0] = mask_q;
            2'd1:    read_data[NUM_LINES-1:0] = edge_q;
            2'd2:    read_data[NUM_LINES-1:0] = pending;
            default: read_data[NUM_LINES-1:0] = in_service_q;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: register table, directed nesting/edge/withdrawal/reset sequences, random run vs model.
module tb_irq_controller;

    localparam int N  = 6;
    localparam int SS = 2;

    logic         clk;
    logic         reset;
    logic [N-1:0] irq_in;
    logic [1:0]   address;
    logic         write_enable;
    logic [31:0]  write_data;
    logic [31:0]  read_data;
    logic         irq_out;
    logic [2:0]   irq_id;
    logic         irq_ack;

    int n_tests = 0;
    int n_fail  = 0;

    irq_controller #(.NUM_LINES(N), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .address(address),
        .write_enable(write_enable), .write_data(write_data), .read_data(read_data),
        .irq_out(irq_out), .irq_id(irq_id), .irq_ack(irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: state of each register as the rules describe it, stepped once per clock.
    bit [N-1:0] m_sh [SS];
    bit [N-1:0] m_prev, m_mask, m_edge, m_lat, m_isv;
    bit         m_req;
    int         m_id;

    function automatic int top_bit(input bit [N-1:0] v);
        for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit [N-1:0] m_pend();
        bit [N-1:0] s, p;
        s = m_sh[SS-1];
        p = '0;
        for (int i = 0; i < N; i++)
            p[i] = m_edge[i] ? (m_lat[i] | (s[i] & ~m_prev[i])) : s[i];
        return p;
    endfunction

    function automatic int m_best();
        bit [N-1:0] p, e;
        int t;
        p = m_pend();
        t = top_bit(m_isv);
        e = '0;
        for (int i = 0; i < N; i++) e[i] = (i > t) && p[i] && m_mask[i];
        return top_bit(e);
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        bit [N-1:0] v;
        case (a)
            2'd0:    v = m_mask;
            2'd1:    v = m_edge;
            2'd2:    v = m_pend();
            default: v = m_isv;
        endcase
        return {{(32-N){1'b0}}, v};
    endfunction

    task automatic m_reset();
        for (int k = 0; k < SS; k++) m_sh[k] = '0;
        m_prev = '0; m_mask = '0; m_edge = '0; m_lat = '0; m_isv = '0;
        m_req = 1'b0; m_id = 0;
    endtask

    task automatic m_step();
        bit [N-1:0] s, rise, clr, chg, aset;
        int b, t;
        s = m_sh[SS-1];
        rise = s & ~m_prev & m_edge;
        clr = '0; chg = '0; aset = '0;
        b = m_best();
        t = top_bit(m_isv);
        if (m_req) begin
            if (irq_ack) begin aset[m_id] = 1'b1; m_req = 1'b0; end
            else if (b >= 0) m_id = b;
            else m_req = 1'b0;
        end else if (b >= 0) begin
            m_req = 1'b1; m_id = b;
        end
        if (write_enable) begin
            case (address)
                2'd0: m_mask = write_data[N-1:0];
                2'd1: begin chg = m_edge ^ write_data[N-1:0]; m_edge = write_data[N-1:0]; end
                2'd2: clr = write_data[N-1:0];
                default: if (t >= 0) m_isv[t] = 1'b0;
            endcase
        end
        clr   = clr | aset;
        m_lat = ((m_lat & ~clr) | rise) & ~chg;
        m_isv = m_isv | aset;
        m_prev = s;
        for (int k = SS - 1; k > 0; k--) m_sh[k] = m_sh[k-1];
        m_sh[0] = irq_in;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) m_reset();
        else        m_step();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("model irq_out", irq_out, m_req);
        if (m_req) chk("model irq_id", irq_id, m_id);
        chk("model read_data", read_data, m_read(address));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; write_enable = 1'b1; write_data = d;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        address = a;
        #1;
        chk(nm, read_data, e);
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t tbl [7];

    initial begin
        tbl[0] = '{2'd0, 32'hFFFF_FFFF, 32'h3F};
        tbl[1] = '{2'd0, 32'h0000_0015, 32'h15};
        tbl[2] = '{2'd1, 32'h0000_002A, 32'h2A};
        tbl[3] = '{2'd1, 32'hFFFF_FFC0, 32'h00};
        tbl[4] = '{2'd2, 32'h0000_003F, 32'h00};
        tbl[5] = '{2'd3, 32'h0000_0001, 32'h00};
        tbl[6] = '{2'd0, 32'h0000_0000, 32'h00};

        m_reset();
        reset = 1'b0; irq_in = 6'h3F; address = 2'd0;
        write_enable = 1'b0; write_data = '0; irq_ack = 1'b0;

        // Reset held with all lines high.
        repeat (3) @(negedge clk);
        chk("reset irq_out", irq_out, 0);
        chk("reset irq_id", irq_id, 0);
        for (int a = 0; a < 4; a++) rd(2'(a), 0, "reset read");
        reset = 1'b1;
        ticks(5);
        chk("mask0 no request", irq_out, 0);
        rd(2'd2, 32'h3F, "level pending raw");
        irq_in = '0;
        ticks(3);

        for (int i = 0; i < 7; i++) begin
            wr(tbl[i].addr, tbl[i].wdata);
            rd(tbl[i].addr, tbl[i].exp, "register table");
        end

        // Level requests, latency and in-service blocking.
        wr(2'd0, 32'h3F);
        irq_in = 6'b000101;
        ticks(2);
        chk("latency not yet", irq_out, 0);
        tick();
        chk("latency irq_out", irq_out, 1);
        chk("highest id 2", irq_id, 2);
        ack();
        chk("ack drops irq_out", irq_out, 0);
        rd(2'd3, 32'h04, "in_service after ack");
        ticks(3);
        chk("line0 blocked", irq_out, 0);
        wr(2'd3, 0);
        rd(2'd3, 0, "eoi clears");
        chk("idle after eoi", irq_out, 0);
        tick();
        chk("line2 re-request", irq_out, 1);
        chk("line2 re-request id", irq_id, 2);
        irq_in = '0;
        ack();
        ticks(3);
        wr(2'd3, 0);

        // Nesting.
        irq_in = 6'b000010;
        ticks(3);
        chk("nest line1", irq_id, 1);
        ack();
        irq_in = 6'b010010;
        ticks(3);
        chk("nest preempt out", irq_out, 1);
        chk("nest preempt id", irq_id, 4);
        irq_in = 6'b010011;
        ticks(2);
        chk("nest line0 no change", irq_id, 4);
        ack();
        rd(2'd3, 32'h12, "nested in_service");
        ticks(2);
        chk("line0 held off", irq_out, 0);
        irq_in = '0;
        ticks(3);
        wr(2'd3, 0);
        rd(2'd3, 32'h02, "eoi clears top only");
        wr(2'd3, 0);
        rd(2'd3, 0, "second eoi");

        // Edge latch on line 3.
        wr(2'd1, 32'h08);
        irq_in = 6'b001000;
        tick();
        irq_in = '0;
        ticks(2);
        chk("edge request", irq_out, 1);
        chk("edge id", irq_id, 3);
        ticks(3);
        rd(2'd2, 32'h08, "edge pending persists");
        wr(2'd2, 32'h08);
        rd(2'd2, 0, "w1c clears pending");
        tick();
        chk("w1c withdraws", irq_out, 0);
        wr(2'd1, 0);

        // Withdrawal by mask, then preemption while requesting.
        irq_in = 6'b000010;
        ticks(3);
        chk("line1 req", irq_out, 1);
        wr(2'd0, 0);
        tick();
        chk("mask withdraws", irq_out, 0);
        wr(2'd0, 32'h3F);
        tick();
        chk("line1 req again", irq_out, 1);
        chk("line1 id again", irq_id, 1);
        irq_in = 6'b100010;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("preempt keeps irq_out", irq_out, 1);
        end
        chk("preempt id 5", irq_id, 5);
        ack();
        irq_in = '0;
        ticks(3);
        wr(2'd3, 0);
        rd(2'd3, 0, "clean after preempt");

        // Asynchronous reset in the middle of a request.
        irq_in = 6'b000010;
        ticks(3);
        ack();
        irq_in = 6'b010010;
        ticks(3);
        chk("pre-reset req", irq_out, 1);
        #2 reset = 1'b0;
        #1 chk("async reset irq_out", irq_out, 0);
        chk("async reset irq_id", irq_id, 0);
        address = 2'd3;
        #1 chk("async reset in_service", read_data, 0);
        @(negedge clk);
        reset = 1'b1;
        irq_in = '0;
        ticks(4);

        // Random traffic against the model.
        wr(2'd0, 32'h3F);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(2) == 0) irq_in = 6'($urandom);
            irq_ack      = ($urandom_range(3) == 0);
            write_enable = ($urandom_range(5) == 0);
            address      = 2'($urandom);
            write_data   = $urandom;
            tick();
        end
        irq_ack = 1'b0;
        write_enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
